booth_signed_divider: RTL and testbench

- Sequential signed radix-2 restoring divider. It is the inverse datapath to the pipelined Radix-4 Booth multiplier.
- It takes a WIDTH-bit signed dividend and divisor, divides their magnitudes one quotient bit per cycle, then applies sign correction.
- Quotient sign is the XOR of the operand signs, the same rule the multiplier uses for its product sign. Remainder sign follows the dividend.
- It sits beside the multiplier in the arithmetic unit and uses the same load-style start interface.

---
 rtl/booth_signed_divider_if.sv | 25 ++
 rtl/booth_signed_divider.sv | 138 +++++++++++++
 tb/tb_booth_signed_divider.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/booth_signed_divider_if.sv
// Start/result interface of the signed restoring divider; mirrors the load-style
// interface of the Booth multiplier that sits beside it.
interface booth_signed_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output load, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  load, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/booth_signed_divider.sv
// Sequential signed radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, then sign correction. Fixed latency of WIDTH+1 cycles from load.
module booth_signed_divider #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    booth_signed_divider_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StDivide, StFix} state_e;

    state_e           state_q, state_d;
    logic             sign_n_q, sign_n_d;
    logic             sign_d_q, sign_d_d;
    logic             dz_cap_q, dz_cap_d;
    logic             ovf_cap_q, ovf_cap_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d;   // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] most_neg;

    assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    assign shifted  = {rem_q, a_mag_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, b_mag_q};

    always_comb begin
        state_d       = state_q;
        sign_n_d      = sign_n_q;
        sign_d_d      = sign_d_q;
        dz_cap_d      = dz_cap_q;
        ovf_cap_d     = ovf_cap_q;
        dividend_d    = dividend_q;
        a_mag_d       = a_mag_q;
        b_mag_d       = b_mag_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    sign_n_d   = bus.dividend[WIDTH-1];
                    sign_d_d   = bus.divisor[WIDTH-1];
                    dividend_d = bus.dividend;
                    // Magnitudes are unsigned, so |most-negative| wraps to the right value.
                    a_mag_d    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                    b_mag_d    = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
                    dz_cap_d   = (bus.divisor == '0);
                    ovf_cap_d  = (bus.dividend == most_neg) && (bus.divisor == '1);
                    rem_d      = '0;
                    cnt_d      = CntW'(WIDTH - 1);
                    state_d    = StDivide;
                end
            end
            StDivide: begin
                a_mag_d = {a_mag_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dz_cap_q) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                end else begin
                    quotient_d  = (sign_n_q ^ sign_d_q) ? -a_mag_q : a_mag_q;
                    remainder_d = sign_n_q ? -rem_q : rem_q;
                end
                div_by_zero_d = dz_cap_q;
                overflow_d    = ovf_cap_q && !dz_cap_q;
                done_d        = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            sign_n_q      <= 1'b0;
            sign_d_q      <= 1'b0;
            dz_cap_q      <= 1'b0;
            ovf_cap_q     <= 1'b0;
            dividend_q    <= '0;
            a_mag_q       <= '0;
            b_mag_q       <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_n_q      <= sign_n_d;
            sign_d_q      <= sign_d_d;
            dz_cap_q      <= dz_cap_d;
            ovf_cap_q     <= ovf_cap_d;
            dividend_q    <= dividend_d;
            a_mag_q       <= a_mag_d;
            b_mag_q       <= b_mag_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_booth_signed_divider.sv
// Scoreboard bench for booth_signed_divider: an integer reference model predicts each
// result when the load is driven; results are popped and compared when done pulses.
module tb_booth_signed_divider;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    booth_signed_divider_if #(.WIDTH(W)) bus ();

    booth_signed_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        int   r;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            q    = -1;
            r    = a;
            e.dz = 1'b1;
        end else if (a == -(1 << (W - 1)) && b == -1) begin
            q    = a;
            r    = 0;
            e.ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.q = q[W-1:0];
        e.r = r[W-1:0];
        return e;
    endfunction

    // Drive a load at the current negedge; the load is sampled at the next posedge (E0).
    task automatic issue(input int a, input int b);
        bus.load     = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[W-1:0];
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.load = 1'b0;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("busy_after_load", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_result(input bit pulse_busy_load);
        int   n;
        int   bc;
        exp_t e;
        n  = 0;
        bc = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) bc++;
            if (pulse_busy_load && n == 2) begin
                bus.load     = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end else if (n == 3) begin
                bus.load = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.load = 1'b0;
        check("latency", n, W + 1);
        check("busy_cycles", bc, W + 1);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("quotient", {24'd0, bus.quotient}, {24'd0, e.q});
            check("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
            check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
            check("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
        end
    endtask

    task automatic run_div(input int a, input int b, input bit pulse = 1'b0);
        @(negedge clk);
        issue(a, b);
        wait_result(pulse);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_q"}, {24'd0, bus.quotient}, 32'd0);
        check({tag, "_r"}, {24'd0, bus.remainder}, 32'd0);
        check({tag, "_flags"}, {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    endtask

    initial begin
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        n_checks     = 0;
        n_errors     = 0;
        bus.load     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;

        run_div(100, 7);
        run_div(-100, 7);
        run_div(100, -7);
        run_div(-100, -7);
        run_div(-128, -1);
        run_div(-128, 1);
        run_div(0, -5);
        run_div(5, 0);
        run_div(9, 3);

        // Load pulsed mid-division is ignored; next load lands on the done-drop edge.
        run_div(100, 7, 1'b1);
        issue(50, 5);
        wait_result(1'b0);

        // Asynchronous reset mid-division aborts without a done pulse.
        @(negedge clk);
        issue(100, 7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_cleared("abort");
        sb.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;
        run_div(-1, 1);

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_div(int'(ra), int'(rb));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
